// File: rtl/vcr_ugal_credit_tracker.sv
// vcr_ugal_credit_tracker: per-channel/per-VC downstream occupancy counters for UGAL; define VCR_UGAL_TRACKER_ERR_EN for sticky error flags
module vcr_ugal_credit_tracker #(
  parameter int num_channels = 6,
  parameter int num_vcs = 2,
  parameter int num_flit_buffers = 8,
  parameter int congestion_threshold = 12,
  localparam int vc_idx_width = $clog2(num_vcs),
  localparam int vc_count_width = $clog2(num_flit_buffers + 1),
  localparam int agg_count_width = $clog2(num_vcs * num_flit_buffers + 1)
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [num_channels*(2+vc_idx_width)-1:0]          flit_ctrl,
  input  logic [num_channels*(1+vc_idx_width)-1:0]          flow_ctrl,
  output logic [num_channels*num_vcs*vc_count_width-1:0]    vc_count,
  output logic [num_channels*agg_count_width-1:0]           agg_count,
  output logic [num_channels-1:0]                           congested,
  output logic [num_channels-1:0]                           error
);
  localparam int fw = 2 + vc_idx_width;
  localparam int cw = 1 + vc_idx_width;
  localparam int nw = vc_count_width;
  localparam int aw = agg_count_width;
  for (genvar c = 0; c < num_channels; c++) begin : g_ch
    logic f_v, c_v, unused_head;
    logic [vc_idx_width-1:0] f_vc, c_vc;
    logic [num_vcs-1:0] ovf, unf;
    logic [aw-1:0] sum;
    assign f_v = flit_ctrl[c*fw + fw - 1];
    assign f_vc = flit_ctrl[c*fw + 1 +: vc_idx_width];
    assign unused_head = flit_ctrl[c*fw];
    assign c_v = flow_ctrl[c*cw + cw - 1];
    assign c_vc = flow_ctrl[c*cw +: vc_idx_width];
    for (genvar v = 0; v < num_vcs; v++) begin : g_vc
      logic inc, dec;
      logic [nw-1:0] cnt;
      assign inc = f_v && f_vc == vc_idx_width'(v);
      assign dec = c_v && c_vc == vc_idx_width'(v);
      // a matched flit and credit cancel, so saturation only applies to lone events
      assign ovf[v] = inc && !dec && cnt == nw'(num_flit_buffers);
      assign unf[v] = dec && !inc && cnt == '0;
      always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (inc && !dec && !ovf[v]) cnt <= cnt + 1'b1;
        else if (dec && !inc && !unf[v]) cnt <= cnt - 1'b1;
      assign vc_count[(c*num_vcs + v)*nw +: nw] = cnt;
    end
    always_comb begin
      sum = '0;
      for (int v = 0; v < num_vcs; v++) sum = sum + aw'(vc_count[(c*num_vcs + v)*nw +: nw]);
    end
    assign agg_count[c*aw +: aw] = sum;
    assign congested[c] = int'(sum) >= congestion_threshold;
`ifdef VCR_UGAL_TRACKER_ERR_EN
    logic err;
    always_ff @(posedge clk or posedge reset)
      if (reset) err <= 1'b0;
      else if (|{ovf, unf}) err <= 1'b1;
    assign error[c] = err;
`else
    logic unused_err;
    assign unused_err = |{ovf, unf};
    assign error[c] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_vcr_ugal_credit_tracker.sv
// tb_vcr_ugal_credit_tracker: table-driven vectors plus reference-model scoreboard for the credit tracker
module tb_vcr_ugal_credit_tracker;
  localparam int nc = 6, nv = 2, nb = 8, th = 12, vw = 1, cw = 4, aw = 5;
`ifdef VCR_UGAL_TRACKER_ERR_EN
  localparam bit err_en = 1'b1;
`else
  localparam bit err_en = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [nc*(2+vw)-1:0] flit_ctrl = '0;
  logic [nc*(1+vw)-1:0] flow_ctrl = '0;
  logic [nc*nv*cw-1:0] vc_count;
  logic [nc*aw-1:0] agg_count;
  logic [nc-1:0] congested, error;

  vcr_ugal_credit_tracker #(
    .num_channels(nc), .num_vcs(nv), .num_flit_buffers(nb), .congestion_threshold(th)
  ) dut (
    .clk(clk), .reset(reset), .flit_ctrl(flit_ctrl), .flow_ctrl(flow_ctrl),
    .vc_count(vc_count), .agg_count(agg_count), .congested(congested), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [nc*nv*cw-1:0] vc;
    logic [nc*aw-1:0] agg;
    logic [nc-1:0] cong;
    logic [nc-1:0] err;
  } exp_t;
  typedef struct {
    logic [nc-1:0] fv, fvc, cv, cvc;
    int ch, vc, cnt, agg;
    bit cong, err;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int m[nc][nv];
  bit me[nc];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t pack();
    exp_t e;
    e = '0;
    for (int c = 0; c < nc; c++) begin
      int sum;
      sum = 0;
      for (int v = 0; v < nv; v++) begin
        e.vc[(c*nv + v)*cw +: cw] = cw'(m[c][v]);
        sum += m[c][v];
      end
      e.agg[c*aw +: aw] = aw'(sum);
      e.cong[c] = sum >= th;
      e.err[c] = me[c] && err_en;
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < nc; c++) begin
      me[c] = 1'b0;
      for (int v = 0; v < nv; v++) m[c][v] = 0;
    end
  endtask

  task automatic step(input logic [nc-1:0] fv, fvc, cv, cvc);
    exp_t e;
    for (int c = 0; c < nc; c++) begin
      flit_ctrl[c*3 +: 3] = {fv[c], fvc[c], 1'($urandom)};
      flow_ctrl[c*2 +: 2] = {cv[c], cvc[c]};
      for (int v = 0; v < nv; v++) begin
        bit inc, dec;
        inc = fv[c] && int'(fvc[c]) == v;
        dec = cv[c] && int'(cvc[c]) == v;
        if (inc && !dec) begin
          if (m[c][v] == nb) me[c] = 1'b1; else m[c][v]++;
        end else if (dec && !inc) begin
          if (m[c][v] == 0) me[c] = 1'b1; else m[c][v]--;
        end
      end
    end
    sbq.push_back(pack());
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = sbq.pop_front();
      chk("sb_vc_count", 64'(vc_count), 64'(e.vc));
      chk("sb_agg_count", 64'(agg_count), 64'(e.agg));
      chk("sb_congested", 64'(congested), 64'(e.cong));
      chk("sb_error", 64'(error), 64'(e.err));
    end
  endtask

  function automatic vec_t mk(int fch, int fvc, int cch, int cvc, int ch, int vc, int cnt, int agg, bit cong, bit err);
    vec_t r;
    r.fv = '0; r.fvc = '0; r.cv = '0; r.cvc = '0;
    if (fch >= 0) begin r.fv[fch] = 1'b1; r.fvc[fch] = 1'(fvc); end
    if (cch >= 0) begin r.cv[cch] = 1'b1; r.cvc[cch] = 1'(cvc); end
    r.ch = ch; r.vc = vc; r.cnt = cnt; r.agg = agg; r.cong = cong; r.err = err;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, -1, 0, 0, 1, i + 1, i + 1, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(2, 0, -1, 0, 2, 0, i + 1, i + 1, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(2, 1, -1, 0, 2, 1, i + 1, 9 + i, i == 3, 0));
    tbl.push_back(mk(-1, 0, 2, 1, 2, 1, 3, 11, 0, 0));
    tbl.push_back(mk(2, 1, 2, 0, 2, 1, 4, 11, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, -1, 0, 1, 0, i + 1, i + 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 5, 5, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(3, 0, -1, 0, 3, 0, i + 1, i + 1, 0, 0));
    tbl.push_back(mk(3, 0, -1, 0, 3, 0, 8, 8, 0, err_en));
    tbl.push_back(mk(-1, 0, -1, 0, 3, 0, 8, 8, 0, err_en));
    tbl.push_back(mk(-1, 0, 4, 1, 4, 1, 0, 0, 0, err_en));
    tbl.push_back(mk(-1, 0, -1, 0, 0, 1, 3, 3, 0, 0));

    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vc_count", 64'(vc_count), 64'd0);
    chk("reset_agg_count", 64'(agg_count), 64'd0);
    chk("reset_congested", 64'(congested), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].fv, tbl[i].fvc, tbl[i].cv, tbl[i].cvc);
      chk($sformatf("tbl%0d_cnt", i), 64'(vc_count[(tbl[i].ch*nv + tbl[i].vc)*cw +: cw]), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_agg", i), 64'(agg_count[tbl[i].ch*aw +: aw]), 64'(tbl[i].agg));
      chk($sformatf("tbl%0d_cong", i), 64'(congested[tbl[i].ch]), 64'(tbl[i].cong));
      chk($sformatf("tbl%0d_err", i), 64'(error[tbl[i].ch]), 64'(tbl[i].err));
    end

    for (int i = 0; i < 40; i++)
      step(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));

    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_vc_count", 64'(vc_count), 64'd0);
    chk("async_rst_agg_count", 64'(agg_count), 64'd0);
    chk("async_rst_congested", 64'(congested), 64'd0);
    chk("async_rst_error", 64'(error), 64'd0);
    model_clear();
    flit_ctrl[5*3 +: 3] = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_vc_count", 64'(vc_count), 64'd0);
    reset = 1'b0;
    step(6'b100000, 6'b000000, 6'b000000, 6'b000000);
    chk("post_rst_first", 64'(vc_count[(5*nv)*cw +: cw]), 64'd1);
    step('0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
